// File: rtl/i2c_pkg.sv
// Shared I2C target types and constants.
package i2c_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      WR_DATA,
      WR_ACK,
      RD_DATA,
      RD_ACK,
      IGNORE
   } i2c_state_t;

   localparam logic READ_C  = 1'b1;
   localparam logic WRITE_C = 1'b0;

   localparam int I2C_BYTE_BITS = 8;

   // Address byte carries the 7-bit address above the R/W bit.
   function automatic logic addr_match(input logic [I2C_BYTE_BITS-1:0] addr_byte,
                                       input logic [6:0] addr);
      return addr_byte[I2C_BYTE_BITS-1:1] == addr;
   endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Pad synchronizer with history flop and registered edge strobes.
// Pin-to-strobe latency SYNC_STAGES+1 clk; level is aligned with the strobes.
module i2c_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pin,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync;

   // Bus idles high, so the chain resets to 1 to avoid a false edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync  <= '1;
         level <= 1'b1;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         sync  <= {sync[SYNC_STAGES-2:0], pin};
         level <= sync[SYNC_STAGES-1];
         rise  <= sync[SYNC_STAGES-1] & ~level;
         fall  <= ~sync[SYNC_STAGES-1] & level;
      end
   end

endmodule

// File: rtl/i2c_slave.sv
// Fixed-address I2C target: ACKs address/write bytes, shifts out read bytes.
// Line events lag pins by SYNC_STAGES+1 clk; no clock stretching, so tx_data must be ready when tx_req fires.
module i2c_slave
   import i2c_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR  = 7'h50,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_oe,
   output logic       rx_valid,
   output logic [7:0] rx_data,
   output logic       tx_req,
   input  logic [7:0] tx_data,
   output logic       start_det,
   output logic       stop_det,
   output logic       busy,
   output logic       nack_rx
);

   localparam logic [2:0] LAST_BIT = 3'(I2C_BYTE_BITS - 1);

   logic scl_lvl, scl_rise, scl_fall;
   logic sda_lvl, sda_rise, sda_fall;

   i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .pin   (scl_i),
      .level (scl_lvl),
      .rise  (scl_rise),
      .fall  (scl_fall)
   );

   i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .pin   (sda_i),
      .level (sda_lvl),
      .rise  (sda_rise),
      .fall  (sda_fall)
   );

   logic start_cond, stop_cond;
   assign start_cond = sda_fall & scl_lvl;
   assign stop_cond  = sda_rise & scl_lvl;

   i2c_state_t                 state;
   logic [2:0]                 bit_cnt;
   logic                       bits_done;
   logic [I2C_BYTE_BITS-1:0]   shift;
   logic [I2C_BYTE_BITS-1:0]   tx_shift;
   logic                       rw_bit;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         sda_oe    <= 1'b0;
         busy      <= 1'b0;
         rx_valid  <= 1'b0;
         rx_data   <= '0;
         tx_req    <= 1'b0;
         start_det <= 1'b0;
         stop_det  <= 1'b0;
         nack_rx   <= 1'b0;
         bit_cnt   <= '0;
         bits_done <= 1'b0;
         shift     <= '0;
         tx_shift  <= '0;
         rw_bit    <= WRITE_C;
      end else begin
         rx_valid  <= 1'b0;
         tx_req    <= 1'b0;
         start_det <= 1'b0;
         stop_det  <= 1'b0;
         nack_rx   <= 1'b0;

         if (start_cond) begin
            start_det <= 1'b1;
            state     <= ADDR;
            bit_cnt   <= '0;
            bits_done <= 1'b0;
            shift     <= '0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
         end else if (stop_cond) begin
            stop_det  <= 1'b1;
            state     <= IDLE;
            bit_cnt   <= '0;
            bits_done <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
         end else begin
            case (state)
               IDLE: ;

               ADDR, WR_DATA: begin
                  if (scl_rise) begin
                     shift   <= {shift[I2C_BYTE_BITS-2:0], sda_lvl};
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == LAST_BIT) bits_done <= 1'b1;
                  end else if (scl_fall && bits_done) begin
                     bits_done <= 1'b0;
                     if (state == ADDR) begin
                        if (addr_match(shift, SLAVE_ADDR)) begin
                           sda_oe <= 1'b1;
                           busy   <= 1'b1;
                           rw_bit <= shift[0];
                           state  <= ADDR_ACK;
                        end else begin
                           sda_oe <= 1'b0;
                           state  <= IGNORE;
                        end
                     end else begin
                        rx_data  <= shift;
                        rx_valid <= 1'b1;
                        sda_oe   <= 1'b1;
                        state    <= WR_ACK;
                     end
                  end
               end

               ADDR_ACK: begin
                  if (scl_fall) begin
                     if (rw_bit == READ_C) begin
                        tx_req   <= 1'b1;
                        tx_shift <= tx_data;
                        sda_oe   <= ~tx_data[I2C_BYTE_BITS-1];
                        bit_cnt  <= '0;
                        state    <= RD_DATA;
                     end else begin
                        sda_oe <= 1'b0;
                        state  <= WR_DATA;
                     end
                  end
               end

               WR_ACK: begin
                  if (scl_fall) begin
                     sda_oe <= 1'b0;
                     state  <= WR_DATA;
                  end
               end

               // tx_shift MSB is the bit on the wire; the next one sits just below it.
               RD_DATA: begin
                  if (scl_rise) begin
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == LAST_BIT) bits_done <= 1'b1;
                  end else if (scl_fall) begin
                     if (bits_done) begin
                        bits_done <= 1'b0;
                        sda_oe    <= 1'b0;
                        state     <= RD_ACK;
                     end else begin
                        sda_oe   <= ~tx_shift[I2C_BYTE_BITS-2];
                        tx_shift <= {tx_shift[I2C_BYTE_BITS-2:0], 1'b0};
                     end
                  end
               end

               RD_ACK: begin
                  if (scl_rise && sda_lvl) begin
                     nack_rx <= 1'b1;
                     state   <= IGNORE;
                  end else if (scl_fall) begin
                     tx_req   <= 1'b1;
                     tx_shift <= tx_data;
                     sda_oe   <= ~tx_data[I2C_BYTE_BITS-1];
                     bit_cnt  <= '0;
                     state    <= RD_DATA;
                  end
               end

               IGNORE: sda_oe <= 1'b0;

               default: begin
                  sda_oe <= 1'b0;
                  state  <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench: bit-level I2C master drives the target; checks pulses, levels and bytes.
module tb_i2c_slave;
   import i2c_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       m_scl, m_sda;
   logic       bus_sda;
   logic       sda_oe, rx_valid, tx_req, start_det, stop_det, busy, nack_rx;
   logic [7:0] rx_data, tx_data;
   logic [7:0] tx_tab [16];

   int n_rx = 0, n_tx = 0, n_nack = 0, n_start = 0, n_stop = 0, n_oe = 0, n_busy = 0;
   int b_rx, b_tx, b_nack, b_start, b_stop, b_oe, b_busy;
   int n_tests = 0, n_fail = 0;

   logic       ack;
   logic       bit_v;
   logic [7:0] d0, d1;

   always #5 clk = ~clk;

   assign bus_sda = m_sda & ~sda_oe;
   assign tx_data = tx_tab[n_tx[3:0]];

   i2c_slave #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .scl_i     (m_scl),
      .sda_i     (bus_sda),
      .sda_oe    (sda_oe),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .tx_req    (tx_req),
      .tx_data   (tx_data),
      .start_det (start_det),
      .stop_det  (stop_det),
      .busy      (busy),
      .nack_rx   (nack_rx)
   );

   always @(negedge clk) begin
      if (rx_valid)  n_rx++;
      if (tx_req)    n_tx++;
      if (nack_rx)   n_nack++;
      if (start_det) n_start++;
      if (stop_det)  n_stop++;
      if (sda_oe)    n_oe++;
      if (busy)      n_busy++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic snap();
      b_rx = n_rx; b_tx = n_tx; b_nack = n_nack; b_start = n_start;
      b_stop = n_stop; b_oe = n_oe; b_busy = n_busy;
   endtask

   task automatic wait_q();
      repeat (8) @(negedge clk);
   endtask

   task automatic i2c_start();
      m_sda = 1'b1; m_scl = 1'b1; wait_q();
      m_sda = 1'b0; wait_q();
      m_scl = 1'b0; wait_q();
   endtask

   task automatic i2c_rstart();
      m_sda = 1'b1; wait_q();
      m_scl = 1'b1; wait_q();
      m_sda = 1'b0; wait_q();
      m_scl = 1'b0; wait_q();
   endtask

   task automatic i2c_stop();
      m_sda = 1'b0; wait_q();
      m_scl = 1'b1; wait_q();
      m_sda = 1'b1; wait_q();
   endtask

   task automatic send_bit(input logic b);
      m_sda = b; wait_q();
      m_scl = 1'b1; wait_q(); wait_q();
      m_scl = 1'b0; wait_q();
   endtask

   task automatic recv_bit(output logic b);
      m_sda = 1'b1; wait_q();
      m_scl = 1'b1; wait_q();
      b = bus_sda; wait_q();
      m_scl = 1'b0; wait_q();
   endtask

   task automatic write_byte(input logic [7:0] d, output logic a);
      for (int i = 7; i >= 0; i--) send_bit(d[i]);
      recv_bit(a);
   endtask

   task automatic read_byte(output logic [7:0] d, input logic nack);
      for (int i = 7; i >= 0; i--) recv_bit(d[i]);
      send_bit(nack);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) tx_tab[i] = 8'hFF;
      m_scl = 1'b1; m_sda = 1'b1; rst_n = 1'b0;
      repeat (5) @(negedge clk);
      chk("reset_sda_oe", 32'(sda_oe), 0);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_rx_data", 32'(rx_data), 0);
      chk("reset_pulses", {rx_valid, tx_req, start_det, stop_det, nack_rx}, 0);
      chk("reset_state", 32'(dut.state), 32'(IDLE));
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // write A5 to 0x50
      snap();
      i2c_start();
      write_byte(8'hA0, ack); chk("wr_addr_ack", 32'(ack), 0);
      chk("wr_busy", 32'(busy), 1);
      write_byte(8'hA5, ack); chk("wr_data_ack", 32'(ack), 0);
      i2c_stop(); wait_q();
      chk("wr_rx_cnt", n_rx - b_rx, 1);
      chk("wr_rx_data", 32'(rx_data), 32'hA5);
      chk("wr_start_cnt", n_start - b_start, 1);
      chk("wr_stop_cnt", n_stop - b_stop, 1);
      chk("wr_busy_end", 32'(busy), 0);
      chk("wr_sda_oe_end", 32'(sda_oe), 0);

      // wrong address 0x51
      snap();
      i2c_start();
      write_byte(8'hA2, ack); chk("bad_addr_nack", 32'(ack), 1);
      write_byte(8'h12, ack); chk("bad_data_nack", 32'(ack), 1);
      i2c_stop(); wait_q();
      chk("bad_rx_cnt", n_rx - b_rx, 0);
      chk("bad_oe_cycles", n_oe - b_oe, 0);
      chk("bad_busy_cycles", n_busy - b_busy, 0);

      // read two bytes, ACK then NACK
      tx_tab[n_tx[3:0]] = 8'h3C;
      tx_tab[4'(n_tx + 1)] = 8'hC3;
      snap();
      i2c_start();
      write_byte(8'hA1, ack); chk("rd_addr_ack", 32'(ack), 0);
      read_byte(d0, 1'b0);
      read_byte(d1, 1'b1);
      chk("rd_byte0", 32'(d0), 32'h3C);
      chk("rd_byte1", 32'(d1), 32'hC3);
      chk("rd_nack_cnt", n_nack - b_nack, 1);
      chk("rd_state_ignore", 32'(dut.state), 32'(IGNORE));
      chk("rd_sda_released", 32'(sda_oe), 0);
      i2c_stop(); wait_q();
      chk("rd_tx_req_cnt", n_tx - b_tx, 2);

      // write then repeated START into a read
      tx_tab[n_tx[3:0]] = 8'h5A;
      snap();
      i2c_start();
      write_byte(8'hA0, ack); chk("rs_addr_ack", 32'(ack), 0);
      write_byte(8'h11, ack); chk("rs_data_ack", 32'(ack), 0);
      i2c_rstart();
      write_byte(8'hA1, ack); chk("rs_raddr_ack", 32'(ack), 0);
      chk("rs_state_rd", 32'(dut.state), 32'(RD_DATA));
      chk("rs_no_stop", n_stop - b_stop, 0);
      read_byte(d0, 1'b1);
      chk("rs_read_byte", 32'(d0), 32'h5A);
      i2c_stop(); wait_q();
      chk("rs_start_cnt", n_start - b_start, 2);
      chk("rs_rx_data", 32'(rx_data), 32'h11);
      chk("rs_tx_req_cnt", n_tx - b_tx, 1);

      // reset while driving a 0 read bit
      tx_tab[n_tx[3:0]] = 8'h00;
      i2c_start();
      write_byte(8'hA1, ack); chk("rst_addr_ack", 32'(ack), 0);
      recv_bit(bit_v); chk("rst_bit7", 32'(bit_v), 0);
      m_sda = 1'b1; wait_q();
      m_scl = 1'b1; wait_q();
      chk("rst_driving", 32'(sda_oe), 1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("rst_sda_oe", 32'(sda_oe), 0);
      chk("rst_state", 32'(dut.state), 32'(IDLE));
      @(negedge clk); rst_n = 1'b1;
      m_scl = 1'b0; wait_q();
      i2c_stop(); wait_q();
      snap();
      i2c_start();
      write_byte(8'hA0, ack); chk("post_rst_addr_ack", 32'(ack), 0);
      write_byte(8'h77, ack); chk("post_rst_data_ack", 32'(ack), 0);
      i2c_stop(); wait_q();
      chk("post_rst_rx_cnt", n_rx - b_rx, 1);
      chk("post_rst_rx_data", 32'(rx_data), 32'h77);

      // STOP after four data bits
      snap();
      i2c_start();
      write_byte(8'hA0, ack); chk("mid_addr_ack", 32'(ack), 0);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
      i2c_stop(); wait_q();
      chk("mid_rx_cnt", n_rx - b_rx, 0);
      chk("mid_state", 32'(dut.state), 32'(IDLE));
      chk("mid_sda_oe", 32'(sda_oe), 0);
      chk("mid_busy", 32'(busy), 0);
      chk("mid_stop_cnt", n_stop - b_stop, 1);
      chk("mid_rx_data_kept", 32'(rx_data), 32'h77);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
Synthesizable I2C target (slave) responding to a single fixed 7-bit address. It oversamples SCL/SDA on the system clock and detects START/STOP. It ACKs address and write bytes and shifts out read bytes. Byte data is exchanged with local logic via simple pulse/strobe ports. It is the responder counterpart to the team's I2C master BFM and is verified against it.

Parameters:
SLAVE_ADDR, 7'h50, 7-bit address this target ACKs
SYNC_STAGES, 2, synchronizer flops on scl_i/sda_i (min 2)

Ports:
clk  in  1  system clock; must be >= 20x SCL frequency
rst_n  in  1  synchronous active-low reset
scl_i  in  1  SCL pad input (asynchronous)
sda_i  in  1  SDA pad input (asynchronous)
sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release
rx_valid  out  1  one-cycle pulse: rx_data holds a byte written by the master
rx_data  out  8  last received write byte; held until the next rx_valid
tx_req  out  1  one-cycle pulse: tx_data is consumed this cycle (pop)
tx_data  in  8  next read byte; must be valid whenever tx_req can pulse (FWFT style)
start_det  out  1  pulse on START or repeated START
stop_det  out  1  pulse on STOP
busy  out  1  high from address match until STOP/START
nack_rx  out  1  pulse when the master NACKs a read byte

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE, sda_oe=0, all pulses 0, busy=0, rx_data=0, bit counter 0. Reset mid-transfer releases SDA on the next clk edge.
- Input path: SYNC_STAGES flops, then one history flop. scl_rise/scl_fall/sda_rise/sda_fall are decoded from the synced vs history values. Pin-to-event latency is SYNC_STAGES+1 clk.
- START = sda_fall while synced SCL=1. STOP = sda_rise while synced SCL=1. Each gives a one-cycle start_det/stop_det.
- START in any state: go to ADDR, clear bit count and shift reg, sda_oe=0, busy=0.
- STOP in any state: go to IDLE, sda_oe=0, busy=0.
- START/STOP take priority over SCL edge processing in the same cycle.
- Bits are sampled on scl_rise (MSB first). SDA drive changes only on scl_fall.
- States (typedef in package):
  - IDLE: wait for START.
  - ADDR: shift 8 bits (7 address + R/W).
    - At the scl_fall after bit 8, if addr==SLAVE_ADDR: sda_oe=1, busy=1, go ADDR_ACK. Otherwise go IGNORE with sda_oe=0.
  - ADDR_ACK: hold ACK for one SCL period. At the next scl_fall, sda_oe=0.
    - R/W=0: go WR_DATA.
    - R/W=1: pulse tx_req, load tx_data, drive MSB (sda_oe=~bit7), go RD_DATA.
  - WR_DATA: shift 8 bits. At the scl_fall after bit 8: rx_data<=shift, rx_valid pulse, sda_oe=1, go WR_ACK.
  - WR_ACK: at the next scl_fall, sda_oe=0, go WR_DATA. Write byte count is unlimited.
  - RD_DATA: at each scl_fall, shift out the next bit (sda_oe=~bit). At the scl_fall after the 8th bit: sda_oe=0, go RD_ACK.
  - RD_ACK: sample SDA on scl_rise.
    - 0 (ACK): at the next scl_fall, tx_req pulse, load tx_data, drive MSB, go RD_DATA.
    - 1 (NACK): nack_rx pulse, go IGNORE.
  - IGNORE: sda_oe=0. Leave only on START/STOP.
- Bit counter is 3 bits and wraps 7->0 at the byte boundary. The ACK bit is not counted.
- No clock stretching; SCL is never driven. No general-call or 10-bit addressing.
- sda_oe is registered; no combinational path from pins to sda_oe.

Decomposition:
- Package i2c_pkg:
  - i2c_state_t enum {IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE}
  - constants READ_C=1'b1, WRITE_C=1'b0
  - localparam I2C_BYTE_BITS=8
- Sub-module i2c_line_sync: synchronizer plus history flop and rise/fall outputs, parameterized by SYNC_STAGES. Instantiated once each for SCL and SDA.
- The FSM and shift/counter logic stay in i2c_slave.

Test Plan:
- Master BFM write to 7'h50, data 8'hA5 -> ACK at address and data, rx_valid once with rx_data=8'hA5, stop_det pulse, busy falls, sda_oe=0.
- Write to 7'h51 -> no ACK (SDA stays high at the ACK bit), no rx_valid, sda_oe never 1, busy stays 0.
- Read 2 bytes from 7'h50 with tx_data giving 8'h3C then 8'hC3, master ACK then NACK -> master receives 3C, C3; tx_req pulses exactly twice; nack_rx once; SDA released after the NACK.
- Write 8'h11, then repeated START and read -> start_det twice, rx_data=8'h11, read path entered without an intervening stop_det.
- Assert rst_n=0 while RD_DATA is driving a 0 bit -> sda_oe=0 on the next clk edge, state IDLE. The next full write transaction completes normally.
- STOP injected mid write byte (after 4 bits) -> IDLE, no rx_valid, sda_oe=0, busy=0.
